if1_pcgen: RTL and testbench
============================

Name: if1_pcgen

Overview:
- IF1 fetch-PC generator and IF1→IF2 pipeline register.
- Holds the architectural fetch PC and drives the BTB lookup index.
- Each fetch, selects the next PC by priority: redirect > BTB-predicted taken > PC+4.
- Issues instruction-memory address requests and hands {pc, prediction} to IF2 over a valid/ready handshake.

Parameters:
- RESET_PC, 32'h1c000000, fetch address after reset.
- IDX_W, 6, BTB index width; index = pc[IDX_W+1:2].

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- bp_pc_low  output  IDX_W  BTB lookup index = pc_q[IDX_W+1:2], combinational
- bp_branch  input  1  BTB predicts taken for bp_pc_low, same cycle
- bp_target  input  32  BTB predicted target, same cycle
- redirect_valid  input  1  mispredict/exception redirect from EX
- redirect_pc  input  32  redirect address
- inst_req  output  1  instruction-memory address request
- inst_addr  output  32  request address, equals pc_q
- inst_addr_ok  input  1  memory accepted the address this cycle
- if1_valid  output  1  IF1→IF2 slot holds a fetch
- if1_pc  output  32  PC of that fetch
- if1_pred_taken  output  1  prediction recorded for that fetch
- if1_pred_target  output  32  predicted target, 0 when not taken
- if2_ready  input  1  IF2 consumes the slot this cycle when if1_valid=1

Behaviour:
- Reset (async, rst_n=0):
  - pc_q=RESET_PC; state=IDLE.
  - inst_req=0; if1_valid=0; if1_pc=0; if1_pred_taken=0; if1_pred_target=0.
- Signal definitions:
  - can_accept = !if1_valid || if2_ready.
  - next_pc = bp_branch ? {bp_target[31:2],2'b00} : pc_q+32'd4.
  - PC addition is 32-bit modular: 32'hfffffffc wraps to 0.
- IDLE:
  - Occupied for exactly one cycle after reset release; inst_req=0.
  - Next state is REQ.
- REQ:
  - inst_req = can_accept && !redirect_valid.
  - On inst_req && inst_addr_ok, registered updates:
    - if1_valid<=1; if1_pc<=pc_q.
    - if1_pred_taken<=bp_branch; if1_pred_target<=bp_branch ? {bp_target[31:2],2'b00} : 0.
    - pc_q<=next_pc; state stays REQ.
  - If inst_req && !inst_addr_ok: hold pc_q, keep requesting.
  - If if1_valid && !if2_ready: state<=STALL.
- STALL:
  - inst_req=0; slot, pc_q and prediction fields held.
  - On if2_ready: if1_valid<=0, state<=REQ.
  - The new request issues the following cycle: one bubble per stall.
- Slot consumption:
  - Whenever if1_valid && if2_ready and no new accept this cycle, if1_valid<=0.
  - Accept and consume in the same cycle: the slot is replaced, with no bubble.
- Redirect (highest priority, REQ or STALL):
  - pc_q<={redirect_pc[31:2],2'b00}; if1_valid<=0; state<=REQ; inst_req forced 0 this cycle.
  - An inst_addr_ok coinciding with the redirect is ignored; the memory side must not see inst_req high that cycle.
- Redirect in IDLE: pc_q is loaded with the redirect address; state still goes to REQ.
- Misaligned bp_target or redirect_pc: bits [1:0] are forced to 0.
- bp_pc_low is always derived from pc_q, so BTB outputs correspond to the address currently requested.
- Reset asserted mid-operation: all state returns to reset values immediately.
- A pending request is abandoned. The memory side must drop it on reset.

Test Plan:
- Reset release, inst_addr_ok=1 every cycle, if2_ready=1, bp_branch=0:
  - IDLE for 1 cycle.
  - inst_addr sequence 1c000000, 1c000004, 1c000008.
  - if1_pc follows one cycle behind; no bubbles.
- BTB hit: pc_q=1c000010, bp_branch=1, bp_target=1c000103 on accept:
  - if1_pred_taken=1; if1_pred_target=1c000100.
  - Next inst_addr=1c000100; bp_pc_low=6'h00 (pc 1c000100 → bits [7:2]).
- Backpressure: if2_ready=0 for 3 cycles with a valid slot:
  - inst_req=0; if1_pc stable.
  - Release → slot clears, next request issues one cycle later with the held pc_q.
- Redirect, redirect_pc=1c000200 in the same cycle as inst_addr_ok with if1_valid=1:
  - inst_req=0 that cycle; if1_valid→0.
  - Next cycle inst_addr=1c000200; no stale fetch reaches IF2.
- Wrap: pc_q=fffffffc, bp_branch=0, accept → next inst_addr=00000000.
- Async reset asserted during STALL:
  - Outputs go to reset values without a clock edge.
  - After release, IDLE then inst_addr=1c000000.

Source files
------------

// File: rtl/if1_pcgen.sv
// IF1 fetch-PC generator: selects the next fetch address (redirect > BTB > PC+4),
// issues instruction-memory requests and holds the IF1->IF2 slot.
module if1_pcgen #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter int unsigned IDX_W    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [IDX_W-1:0] bp_pc_low,
  input  logic             bp_branch,
  input  logic [31:0]      bp_target,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             inst_req,
  output logic [31:0]      inst_addr,
  input  logic             inst_addr_ok,
  output logic             if1_valid,
  output logic [31:0]      if1_pc,
  output logic             if1_pred_taken,
  output logic [31:0]      if1_pred_target,
  input  logic             if2_ready
);

  typedef enum logic [1:0] {StIdle, StReq, StStall} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        can_accept;
  logic        accept;
  logic [31:0] bp_target_al;
  logic [31:0] redirect_al;
  logic [31:0] next_pc;
  logic        unused_low_bits;

  assign bp_target_al = {bp_target[31:2], 2'b00};
  assign redirect_al  = {redirect_pc[31:2], 2'b00};
  assign next_pc      = bp_branch ? bp_target_al : pc_q + 32'd4;
  assign can_accept   = !if1_valid || if2_ready;

  // A redirect suppresses the request so memory never sees a fetch it must discard.
  assign inst_req  = (state_q == StReq) && can_accept && !redirect_valid;
  assign accept    = inst_req && inst_addr_ok;
  assign inst_addr = pc_q;
  assign bp_pc_low = pc_q[IDX_W+1:2];

  assign unused_low_bits = ^{bp_target[1:0], redirect_pc[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      pc_q            <= RESET_PC;
      if1_valid       <= 1'b0;
      if1_pc          <= 32'd0;
      if1_pred_taken  <= 1'b0;
      if1_pred_target <= 32'd0;
    end else if (redirect_valid) begin
      pc_q      <= redirect_al;
      if1_valid <= 1'b0;
      state_q   <= StReq;
    end else begin
      unique case (state_q)
        StIdle: state_q <= StReq;
        StReq: begin
          if (accept) begin
            // Accept and consume in one cycle replaces the slot without a bubble.
            if1_valid       <= 1'b1;
            if1_pc          <= pc_q;
            if1_pred_taken  <= bp_branch;
            if1_pred_target <= bp_branch ? bp_target_al : 32'd0;
            pc_q            <= next_pc;
          end else if (if1_valid) begin
            if (if2_ready) begin
              if1_valid <= 1'b0;
            end else begin
              state_q <= StStall;
            end
          end
        end
        StStall: begin
          if (if2_ready) begin
            if1_valid <= 1'b0;
            state_q   <= StReq;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_if1_pcgen.sv
// Self-checking bench for if1_pcgen: directed scenarios plus randomized traffic
// checked against a flag-based behavioural model of the fetch stage.
module tb_if1_pcgen;

  localparam logic [31:0] RESET_PC = 32'h1c000000;

  logic        clk;
  logic        rst_n;
  logic [5:0]  bp_pc_low;
  logic        bp_branch;
  logic [31:0] bp_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        if1_valid;
  logic [31:0] if1_pc;
  logic        if1_pred_taken;
  logic [31:0] if1_pred_target;
  logic        if2_ready;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: fetch address, IF2 slot contents, and two flags for the
  // post-reset idle cycle and an IF2 backpressure stall.
  logic [31:0] m_pc, m_vpc, m_tgt;
  logic        m_valid, m_taken, m_idle, m_stall;

  if1_pcgen #(.RESET_PC(RESET_PC), .IDX_W(6)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bp_pc_low      (bp_pc_low),
    .bp_branch      (bp_branch),
    .bp_target      (bp_target),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_addr_ok   (inst_addr_ok),
    .if1_valid      (if1_valid),
    .if1_pc         (if1_pc),
    .if1_pred_taken (if1_pred_taken),
    .if1_pred_target(if1_pred_target),
    .if2_ready      (if2_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic exp_req();
    return !m_idle && !m_stall && (!m_valid || if2_ready) && !redirect_valid;
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_vpc = 32'd0; m_tgt = 32'd0;
    m_valid = 1'b0; m_taken = 1'b0; m_idle = 1'b1; m_stall = 1'b0;
  endtask

  task automatic model_clock();
    logic req;
    req = exp_req();
    if (redirect_valid) begin
      m_pc = {redirect_pc[31:2], 2'b00};
      m_valid = 1'b0; m_idle = 1'b0; m_stall = 1'b0;
    end else if (m_idle) begin
      m_idle = 1'b0;
    end else if (m_stall) begin
      if (if2_ready) begin m_valid = 1'b0; m_stall = 1'b0; end
    end else if (req && inst_addr_ok) begin
      m_valid = 1'b1;
      m_vpc   = m_pc;
      m_taken = bp_branch;
      m_tgt   = bp_branch ? {bp_target[31:2], 2'b00} : 32'd0;
      m_pc    = bp_branch ? {bp_target[31:2], 2'b00} : m_pc + 32'd4;
    end else if (m_valid) begin
      if (if2_ready) m_valid = 1'b0;
      else m_stall = 1'b1;
    end
  endtask

  // Advance one clock; called at negedge+1 with inputs already applied.
  task automatic tick();
    model_clock();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bp_branch = 0; bp_target = 0; redirect_valid = 0; redirect_pc = 0;
    inst_addr_ok = 0; if2_ready = 0;
    model_reset();
    @(negedge clk); #1;
    n_cmp++;
    if ({inst_req, if1_valid, if1_pred_taken} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: got %b want 000", {inst_req, if1_valid, if1_pred_taken});
    end
    n_cmp++;
    if (if1_pc !== 32'd0 || if1_pred_target !== 32'd0) begin
      n_err++; $display("FAIL reset_slot: got pc %h tgt %h want 0 0", if1_pc, if1_pred_target);
    end
    n_cmp++;
    if (inst_addr !== RESET_PC) begin
      n_err++; $display("FAIL reset_addr: got %h want %h", inst_addr, RESET_PC);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr;
    if2_ready = 1; inst_addr_ok = 1; bp_branch = 0;
    #1;
    n_cmp++;
    if (inst_req !== 1'b0) begin
      n_err++; $display("FAIL idle_req: got %b want 0", inst_req);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      exp_addr = RESET_PC + 32'(4 * i);
      #1;
      n_cmp++;
      if (inst_req !== 1'b1 || inst_addr !== exp_addr) begin
        n_err++; $display("FAIL seq_addr%0d: got req %b addr %h want 1 %h", i, inst_req, inst_addr,
                          exp_addr);
      end
      if (i > 0) begin
        n_cmp++;
        if (if1_valid !== 1'b1 || if1_pc !== exp_addr - 32'd4) begin
          n_err++; $display("FAIL seq_if1pc%0d: got v %b pc %h want 1 %h", i, if1_valid, if1_pc,
                            exp_addr - 32'd4);
        end
      end
      tick();
    end
  endtask

  task automatic test_btb();
    redirect_valid = 1; redirect_pc = 32'h1c000010;
    #1; tick();
    redirect_valid = 0; bp_branch = 1; bp_target = 32'h1c000103;
    #1;
    n_cmp++;
    if (inst_addr !== 32'h1c000010 || bp_pc_low !== 6'h04) begin
      n_err++; $display("FAIL btb_lookup: got addr %h idx %h want 1c000010 04", inst_addr, bp_pc_low);
    end
    tick();
    bp_branch = 0; bp_target = 0;
    #1;
    n_cmp++;
    if (if1_pred_taken !== 1'b1 || if1_pred_target !== 32'h1c000100 || if1_pc !== 32'h1c000010) begin
      n_err++; $display("FAIL btb_pred: got t %b tgt %h pc %h want 1 1c000100 1c000010",
                        if1_pred_taken, if1_pred_target, if1_pc);
    end
    n_cmp++;
    if (inst_addr !== 32'h1c000100 || bp_pc_low !== 6'h00) begin
      n_err++; $display("FAIL btb_next: got addr %h idx %h want 1c000100 00", inst_addr, bp_pc_low);
    end
  endtask

  task automatic test_backpressure();
    if2_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (inst_req !== 1'b0 || if1_valid !== 1'b1 || if1_pc !== 32'h1c000010) begin
        n_err++; $display("FAIL bp_hold%0d: got req %b v %b pc %h want 0 1 1c000010", i, inst_req,
                          if1_valid, if1_pc);
      end
      tick();
    end
    if2_ready = 1;
    #1;
    n_cmp++;
    if (inst_req !== 1'b0) begin
      n_err++; $display("FAIL bp_release_req: got %b want 0", inst_req);
    end
    tick();
    #1;
    n_cmp++;
    if (if1_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'h1c000100) begin
      n_err++; $display("FAIL bp_resume: got v %b req %b addr %h want 0 1 1c000100", if1_valid,
                        inst_req, inst_addr);
    end
  endtask

  task automatic test_redirect();
    tick();
    redirect_valid = 1; redirect_pc = 32'h1c000200; inst_addr_ok = 1;
    #1;
    n_cmp++;
    if (inst_req !== 1'b0 || if1_valid !== 1'b1) begin
      n_err++; $display("FAIL redir_req: got req %b v %b want 0 1", inst_req, if1_valid);
    end
    tick();
    redirect_valid = 0;
    #1;
    n_cmp++;
    if (if1_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'h1c000200) begin
      n_err++; $display("FAIL redir_next: got v %b req %b addr %h want 0 1 1c000200", if1_valid,
                        inst_req, inst_addr);
    end
    tick();
    #1;
    n_cmp++;
    if (if1_valid !== 1'b1 || if1_pc !== 32'h1c000200) begin
      n_err++; $display("FAIL redir_slot: got v %b pc %h want 1 1c000200", if1_valid, if1_pc);
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1; redirect_pc = 32'hfffffffe;
    #1; tick();
    redirect_valid = 0;
    #1;
    n_cmp++;
    if (inst_addr !== 32'hfffffffc) begin
      n_err++; $display("FAIL wrap_align: got %h want fffffffc", inst_addr);
    end
    tick();
    #1;
    n_cmp++;
    if (inst_addr !== 32'h00000000 || if1_pc !== 32'hfffffffc) begin
      n_err++; $display("FAIL wrap_next: got addr %h pc %h want 00000000 fffffffc", inst_addr, if1_pc);
    end
  endtask

  task automatic test_async_reset();
    if2_ready = 0;
    tick();
    tick();
    #2 rst_n = 0;
    #1;
    model_reset();
    n_cmp++;
    if (if1_valid !== 1'b0 || if1_pc !== 32'd0 || inst_addr !== RESET_PC || inst_req !== 1'b0) begin
      n_err++; $display("FAIL async_rst: got v %b pc %h addr %h req %b want 0 0 %h 0", if1_valid,
                        if1_pc, inst_addr, inst_req, RESET_PC);
    end
    @(posedge clk); @(negedge clk);
    rst_n = 1; if2_ready = 1; inst_addr_ok = 1;
    #1;
    n_cmp++;
    if (inst_req !== 1'b0) begin
      n_err++; $display("FAIL async_idle: got req %b want 0", inst_req);
    end
    tick();
    #1;
    n_cmp++;
    if (inst_req !== 1'b1 || inst_addr !== RESET_PC) begin
      n_err++; $display("FAIL async_restart: got req %b addr %h want 1 %h", inst_req, inst_addr,
                        RESET_PC);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) == 0) begin
        rst_n = 0;
        #1;
        model_reset();
        @(posedge clk); @(negedge clk);
        rst_n = 1;
      end
      bp_branch      = ($urandom_range(99) < 30);
      bp_target      = $urandom();
      redirect_valid = ($urandom_range(99) < 8);
      redirect_pc    = $urandom();
      inst_addr_ok   = ($urandom_range(99) < 70);
      if2_ready      = ($urandom_range(99) < 65);
      #1;
      n_cmp++;
      if (inst_req !== exp_req() || inst_addr !== m_pc || bp_pc_low !== m_pc[7:2]) begin
        n_err++; $display("FAIL rnd_req%0d: got req %b addr %h idx %h want %b %h %h", i, inst_req,
                          inst_addr, bp_pc_low, exp_req(), m_pc, m_pc[7:2]);
      end
      n_cmp++;
      if (if1_valid !== m_valid || if1_pc !== m_vpc || if1_pred_taken !== m_taken ||
          if1_pred_target !== m_tgt) begin
        n_err++; $display("FAIL rnd_slot%0d: got %b %h %b %h want %b %h %b %h", i, if1_valid, if1_pc,
                          if1_pred_taken, if1_pred_target, m_valid, m_vpc, m_taken, m_tgt);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_btb();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
